serial_frame_tx: RTL

//  Transmit side of the serial sync-word link. Takes one DATA_W-bit word per

---
 rtl/serial_frame_pkg.sv | 29 ++
 rtl/serial_frame_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial sync-word link transmitter.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam int SYNC_LEN = 4;

  // Bit 0 goes out first, so the line sees 1,1,0,1 in time order.
  localparam logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1011;

  // Sync bit at position idx of the time-ordered sync sequence.
  function automatic logic sync_bit(input logic [1:0] idx);
    return SYNC_WORD[idx];
  endfunction

  // Largest of three sizes; used to size the shared bit counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sync word, LSB-first payload, optional even
// parity bit, then forced-0 gap bits. Optional parity is enabled by
// defining the macro FRAME_PARITY_EN.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int CNT_W = $clog2(max3(SYNC_LEN, DATA_W, GAP_CYCLES) + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAST_SYNC = cnt_t'(SYNC_LEN - 1);
  localparam cnt_t LAST_DATA = cnt_t'(DATA_W - 1);
  localparam cnt_t PRE_LAST  = cnt_t'((DATA_W > 1) ? DATA_W - 2 : 0);
  localparam cnt_t LAST_GAP  = cnt_t'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  logic par_q;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t            state;
  cnt_t              bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_shift;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  // Payload after this cycle's shift; its bit 0 is the next payload bit.
  assign shreg_shift = shreg >> 1;

  // Frame FSM with shifter and counter; every output is a register loaded
  // with the value it must show in the state being entered.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      // NOTE: asynchronous reset clears every register, including the
      // shifter, so a mid-frame reset leaves no stale payload behind.
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FRAME_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads
      // the register values from before this edge.
      case (state)
        IDLE: begin
          tx_q   <= 1'b0;
          done_q <= 1'b0;
          if (s_valid_i && ready_q) begin
            state   <= SYNC;
            bit_cnt <= '0;
            shreg   <= s_data_i;
            tx_q    <= sync_bit(2'd0);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef FRAME_PARITY_EN
            par_q   <= ^s_data_i;
`endif
          end
        end

        SYNC: begin
          if (bit_cnt == LAST_SYNC) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_q    <= shreg[0];
            done_q  <= !PAR_EN && (DATA_W == 1);
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx_q    <= sync_bit(bit_cnt[1:0] + 2'd1);
          end
        end

        DATA: begin
          shreg <= shreg_shift;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt <= '0;
`ifdef FRAME_PARITY_EN
            state  <= PARITY;
            tx_q   <= par_q;
            done_q <= 1'b1;
`else
            tx_q   <= 1'b0;
            done_q <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state   <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx_q    <= shreg_shift[0];
            done_q  <= !PAR_EN && (bit_cnt == PRE_LAST);
          end
        end

`ifdef FRAME_PARITY_EN
        PARITY: begin
          bit_cnt <= '0;
          tx_q    <= 1'b0;
          done_q  <= 1'b0;
          if (GAP_CYCLES > 0) begin
            state <= GAP;
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
`endif

        GAP: begin
          tx_q   <= 1'b0;
          done_q <= 1'b0;
          if (bit_cnt == LAST_GAP) begin
            state   <= IDLE;
            bit_cnt <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        // NOTE: the default arm recovers from any illegal encoding and,
        // with all outputs assigned, keeps the case from holding stale values.
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          tx_q    <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_o         = tx_q;
  assign s_ready_o    = ready_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule
